// File: rtl/stopwatch_key_sequencer.sv
// Syncs, debounces and arbitrates three push-buttons into one-shot start/pause/stop commands.
// Latency: DEBOUNCE_CYCLES+3 edges from raw press to pulse; no backpressure, pulses are fire-and-forget.
module stopwatch_key_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic async_nreset,
    input  logic key_start_n,
    input  logic key_pause_n,
    input  logic key_stop_n,
    output logic start,
    output logic pause,
    output logic stop,
    output logic locked
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    // Bit order everywhere: [2]=stop, [1]=pause, [0]=start.
    logic [2:0]           key_raw;
    logic [2:0]           sync1;
    logic [2:0]           sync2;
    logic [2:0]           stb;
    logic [2:0]           stb_q;
    logic [2:0]           press;
    logic [CNT_WIDTH-1:0] cnt [3];
    state_t               state;

    assign key_raw = {key_stop_n, key_pause_n, key_start_n};
    assign press   = stb_q & ~stb;

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            sync1 <= '1;
            sync2 <= '1;
            stb   <= '1;
            stb_q <= '1;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            stb_q <= stb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Lower-priority simultaneous presses are dropped, not queued.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state  <= IDLE;
            start  <= 1'b0;
            pause  <= 1'b0;
            stop   <= 1'b0;
            locked <= 1'b0;
        end else begin
            start <= 1'b0;
            pause <= 1'b0;
            stop  <= 1'b0;
            if (state == IDLE) begin
                if (|press) begin
                    state  <= HOLD;
                    locked <= 1'b1;
                    stop   <= press[2];
                    pause  <= press[1] & ~press[2];
                    start  <= press[0] & ~press[1] & ~press[2];
                end
            end else begin
                if (&stb) begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/stopwatch_key_sequencer.md
# stopwatch_key_sequencer

Conditions the three raw push-button inputs of the stopwatch board and turns them into clean single-cycle `start`, `pause` and `stop` commands for the stopwatch controller. Each key is synchronised and debounced. A priority arbiter then issues at most one command per press episode and locks out further commands until every key is released. It sits between the board pins and the stopwatch FSM, and is the only source of its command inputs.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a key change (1 ms at 50 MHz). Minimum value is 2.
- `CNT_WIDTH`, default 16: debounce counter width. It must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `clk`, input, 1 bit: the single clock. All state updates on the rising edge.
- `async_nreset`, input, 1 bit: reset, asynchronous and active-low.
- `key_start_n`, input, 1 bit: raw start key, active-low, asynchronous to `clk`, may bounce.
- `key_pause_n`, input, 1 bit: raw pause key, same properties as `key_start_n`.
- `key_stop_n`, input, 1 bit: raw stop key, same properties as `key_start_n`.
- `start`, output, 1 bit: one-cycle start command pulse, registered.
- `pause`, output, 1 bit: one-cycle pause command pulse, registered.
- `stop`, output, 1 bit: one-cycle stop command pulse, registered.
- `locked`, output, 1 bit: high while the arbiter is in HOLD, registered.

## Operation

**Synchroniser (per key)**
- Two flip-flops, `sync1` then `sync2`.
- Both reset to 1 (released).

**Debouncer (per key)**
- Holds a stable level `stb` (reset 1) and a counter `cnt` (reset 0).
- `sync2 == stb`: `cnt <= 0`. Any single-cycle bounce therefore restarts the count.
- `sync2 != stb` and `cnt == DEBOUNCE_CYCLES-1`: `stb <= sync2` and `cnt <= 0`.
- `sync2 != stb` otherwise: `cnt <= cnt + 1`.
- A press event is `stb` transitioning 1→0, i.e. `stb == 0` while last cycle's `stb` was 1.
- A release of `stb` never generates a command.

**Arbiter FSM (reset state IDLE)**
- IDLE, when one or more press events occur this cycle:
  - Register exactly one pulse for the next cycle, with priority `stop` > `pause` > `start`.
  - Go to HOLD.
  - Lower-priority simultaneous events are discarded, not queued.
- IDLE, no press event: stay in IDLE; all pulses 0.
- HOLD:
  - All press events are ignored.
  - Go to IDLE in the first cycle in which all three `stb` are 1.
  - A key still debounced-pressed keeps the FSM in HOLD indefinitely.
- Pulse outputs: at most one of `start`, `pause`, `stop` is high in any cycle, and each is high for exactly one cycle per issued command.
- `locked`: 1 in every cycle the FSM is in HOLD, including the cycle in which the pulse is high.

**Reset**
- Asserting `async_nreset` at any time, including mid-debounce or mid-pulse, immediately forces:
  - all outputs to 0;
  - FSM to IDLE;
  - `sync1`, `sync2`, `stb` to 1;
  - `cnt` to 0.
- A key still held when reset is released is treated as a fresh press.

## Timing

**Press latency:** raw key falls before edge 1 and stays low. Then:
- `sync2 = 0` after edge 2;
- `stb = 0` after edge `DEBOUNCE_CYCLES+2`;
- the pulse is high in the cycle after edge `DEBOUNCE_CYCLES+3`, for that cycle only.

**Release latency:**
- `stb` returns to 1 `DEBOUNCE_CYCLES+2` edges after the raw rise.
- `locked` falls on the following edge, provided the other keys are released.

**Minimum re-trigger:** after the last key's debounced release, a new press is accepted after a further full debounce of that press. No extra dead time is added.

**Reset values:** `start`, `pause`, `stop` and `locked` are all 0.

**Counter arithmetic:** the counter is unsigned and never exceeds `DEBOUNCE_CYCLES-1`. It has no wrap path.

## Test plan

All scenarios run with `DEBOUNCE_CYCLES=4`.

1. **Clean press:** `key_start_n` falls before edge 1 after reset and is held 20 cycles → `start` is high only in the cycle after edge 7; `pause` and `stop` stay 0; `locked` rises with `start`.
2. **Bounce:** `key_pause_n` toggles low 3 / high 1 repeatedly for 40 cycles → no pulse and `locked` stays 0. The key is then held low → exactly one `pause` pulse, 7 edges after the final fall.
3. **Simultaneous press:** `key_start_n` and `key_stop_n` fall in the same cycle and are held → exactly one `stop` pulse; `start` is never asserted.
4. **Lockout:**
   - Hold pause (pulse issued).
   - Press stop while pause is still held → no `stop` pulse; `locked` stays 1.
   - Release both → `locked` falls 7 edges after the later release.
   - Press stop again → `stop` pulses.
5. **Long hold:** `key_stop_n` held low for 1000 cycles → a single `stop` pulse; `locked` stays 1 until 7 edges after release.
6. **Reset mid-operation:**
   - Assert `async_nreset` low while `key_start_n` is held and `cnt` is 2 → all outputs are 0 immediately.
   - Release reset with the key still held → `start` pulses in the cycle after edge 7 following reset release.
